ltl_monitor_sequencer: RTL and testbench

Controller that sequences one LTL automata cluster (a generated `Automata_*` block with `run`/`reset`/`symbols`/report outputs). It buffers an incoming trace-symbol stream and brackets each trace with the automata reset pulse that produces `start_of_data`. It issues one symbol per `run` cycle and aggregates the cluster's report lines into sticky verdict outputs. It sits between the trace-capture front end and the monitor cluster.

---
 rtl/ltl_seq_pkg.sv | 15 +
 rtl/ltl_seq_fifo.sv | 54 +++++
 rtl/ltl_monitor_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_ltl_monitor_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ltl_seq_pkg.sv
// Shared types and constants for the LTL monitor sequencer.
package ltl_seq_pkg;

  localparam int SYM_W         = 8;
  localparam int LTL_SEQ_CNT_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RST   = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } ltl_seq_state_e;

endpackage

// File: rtl/ltl_seq_fifo.sv
// Synchronous symbol FIFO with a flush that empties it on the next edge.
module ltl_seq_fifo
  import ltl_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic             i_wr_en,
  input  logic [SYM_W-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [SYM_W-1:0] o_rd_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [SYM_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_cnt;
  logic             w_wr;
  logic             w_rd;

  assign o_full    = (r_cnt == (AW+1)'(DEPTH));
  assign o_empty   = (r_cnt == '0);
  assign w_wr      = i_wr_en & ~o_full;
  assign w_rd      = i_rd_en & ~o_empty;
  assign o_rd_data = r_mem[r_rptr];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else if (i_flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + AW'(1);
      if (w_rd) r_rptr <= r_rptr + AW'(1);
      r_cnt <= r_cnt + (AW+1)'(w_wr) - (AW+1)'(w_rd);
    end
  end

  // Storage needs no reset; occupancy is tracked by r_cnt.
  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wptr] <= i_wr_data;
  end

endmodule

// File: rtl/ltl_monitor_sequencer.sv
// Sequences one LTL automata cluster: buffers trace symbols, brackets the trace with
// the automata reset, and folds report lines into sticky verdicts. LTL_SEQ_REPORT_IDX_EN adds o_report_idx.
module ltl_monitor_sequencer
  import ltl_seq_pkg::*;
#(
  parameter int NUM_REPORTS  = 4,
  parameter int FIFO_DEPTH   = 4,
  parameter int RESET_CYCLES = 2,
  parameter int CNT_W        = LTL_SEQ_CNT_W
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_start,
  input  logic                   i_stop,
  input  logic                   i_sym_valid,
  input  logic [SYM_W-1:0]       i_sym_data,
  output logic                   o_sym_ready,
  output logic                   o_auto_reset,
  output logic                   o_auto_run,
  output logic [SYM_W-1:0]       o_auto_symbols,
  input  logic [NUM_REPORTS-1:0] i_auto_report,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_violation,
  output logic [NUM_REPORTS-1:0] o_report_vec,
  output logic [CNT_W-1:0]       o_sym_count
`ifdef LTL_SEQ_REPORT_IDX_EN
  ,
  output logic [CNT_W-1:0]       o_report_idx
`endif
);

  localparam int RCW = $clog2(RESET_CYCLES + 1);

  ltl_seq_state_e r_state;
  ltl_seq_state_e w_nxt;

  logic [RCW-1:0]         r_rst_cnt;
  logic                   r_stop_seen;
  logic                   r_rdy_en;
  logic                   r_auto_reset;
  logic                   r_auto_run;
  logic [SYM_W-1:0]       r_auto_symbols;
  logic                   r_run_q;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_violation;
  logic [NUM_REPORTS-1:0] r_report_vec;
  logic [CNT_W-1:0]       r_sym_count;

  logic                   w_stop_nxt;
  logic                   w_pop;
  logic                   w_rst_exp;
  logic                   w_full;
  logic                   w_empty;
  logic                   w_wr;
  logic [SYM_W-1:0]       w_fifo_data;

  assign w_rst_exp   = (r_rst_cnt >= RCW'(RESET_CYCLES - 1));
  // Ready enable is registered; full gates it in the same cycle.
  assign o_sym_ready = r_rdy_en & ~w_full;
  assign w_wr        = i_sym_valid & o_sym_ready;

  ltl_seq_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk     (i_clk),
    .i_rst     (i_reset),
    .i_flush   (i_start),
    .i_wr_en   (w_wr),
    .i_wr_data (i_sym_data),
    .i_rd_en   (w_pop),
    .o_rd_data (w_fifo_data),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  always_comb begin
    w_nxt      = r_state;
    w_pop      = 1'b0;
    w_stop_nxt = r_stop_seen;
    if (i_start) begin
      w_nxt      = ST_RST;
      w_stop_nxt = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: ;
        ST_RST: begin
          if (i_stop) w_stop_nxt = 1'b1;
          if (w_rst_exp && !w_empty) begin
            w_nxt = ST_RUN;
            w_pop = 1'b1;
          end else if (w_rst_exp && r_stop_seen) begin
            w_nxt = ST_DRAIN;
          end
        end
        ST_RUN: begin
          if (i_stop) w_stop_nxt = 1'b1;
          if (!w_empty) w_pop = 1'b1;
          else if (r_stop_seen) w_nxt = ST_DRAIN;
        end
        ST_DRAIN: w_nxt = ST_DONE;
        ST_DONE:  w_nxt = ST_IDLE;
        default:  w_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state        <= ST_IDLE;
      r_rst_cnt      <= '0;
      r_stop_seen    <= 1'b0;
      r_rdy_en       <= 1'b0;
      r_auto_reset   <= 1'b1;
      r_auto_run     <= 1'b0;
      r_auto_symbols <= '0;
      r_run_q        <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_violation    <= 1'b0;
      r_report_vec   <= '0;
      r_sym_count    <= '0;
    end else begin
      r_state     <= w_nxt;
      r_stop_seen <= w_stop_nxt;
      r_busy      <= (w_nxt != ST_IDLE);
      r_done      <= (w_nxt == ST_DONE);
      r_rdy_en    <= ((w_nxt == ST_RST) || (w_nxt == ST_RUN)) && !w_stop_nxt;
      // Dropping reset on the pop edge lines start_of_data up with symbol 0.
      r_auto_reset <= !((w_nxt == ST_RUN) || (w_nxt == ST_DRAIN));
      r_auto_run   <= w_pop;
      if (w_pop) r_auto_symbols <= w_fifo_data;
      r_run_q <= r_auto_run & ~i_start;

      if (r_state == ST_RST && !w_rst_exp) r_rst_cnt <= r_rst_cnt + RCW'(1);

      if (i_start) begin
        r_rst_cnt    <= '0;
        r_sym_count  <= '0;
        r_violation  <= 1'b0;
        r_report_vec <= '0;
      end else begin
        if (w_pop && !(&r_sym_count)) r_sym_count <= r_sym_count + CNT_W'(1);
        if (r_run_q) begin
          r_report_vec <= r_report_vec | i_auto_report;
          r_violation  <= r_violation | (|i_auto_report);
        end
      end
    end
  end

`ifdef LTL_SEQ_REPORT_IDX_EN
  logic [CNT_W-1:0] r_q_idx;
  logic [CNT_W-1:0] r_report_idx;

  // r_q_idx trails the issue by one cycle so it names the symbol run_q qualifies.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_q_idx      <= '0;
      r_report_idx <= '0;
    end else begin
      r_q_idx <= r_sym_count - CNT_W'(1);
      if (i_start) r_report_idx <= '0;
      else if (r_run_q && !r_violation && (|i_auto_report)) r_report_idx <= r_q_idx;
    end
  end

  assign o_report_idx = r_report_idx;
`endif

  assign o_auto_reset   = r_auto_reset;
  assign o_auto_run     = r_auto_run;
  assign o_auto_symbols = r_auto_symbols;
  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_violation    = r_violation;
  assign o_report_vec   = r_report_vec;
  assign o_sym_count    = r_sym_count;

endmodule

// File: tb/tb_ltl_monitor_sequencer.sv
// Scoreboard bench for ltl_monitor_sequencer with a reactive automata report model.
module tb_ltl_monitor_sequencer;
  import ltl_seq_pkg::*;

  localparam int NR = 4;
  localparam int FD = 4;
  localparam int RC = 6;
  localparam int CW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start, stop, sym_valid;
  logic [7:0]    sym_data;
  logic [NR-1:0] auto_report;
  logic          sym_ready, auto_reset, auto_run, busy, done, violation;
  logic [7:0]    auto_symbols;
  logic [NR-1:0] report_vec;
  logic [CW-1:0] sym_count;
`ifdef LTL_SEQ_REPORT_IDX_EN
  logic [CW-1:0] report_idx;
`endif

  ltl_monitor_sequencer #(
    .NUM_REPORTS (NR), .FIFO_DEPTH (FD), .RESET_CYCLES (RC), .CNT_W (CW)
  ) dut (
    .i_clk (clk), .i_reset (rst), .i_start (start), .i_stop (stop),
    .i_sym_valid (sym_valid), .i_sym_data (sym_data), .o_sym_ready (sym_ready),
    .o_auto_reset (auto_reset), .o_auto_run (auto_run), .o_auto_symbols (auto_symbols),
    .i_auto_report (auto_report), .o_busy (busy), .o_done (done),
    .o_violation (violation), .o_report_vec (report_vec), .o_sym_count (sym_count)
`ifdef LTL_SEQ_REPORT_IDX_EN
    , .o_report_idx (report_idx)
`endif
  );

  typedef struct {
    logic [7:0] sym;
    int         idx;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_chk = 0;
  int   n_pass = 0;
  int   push_idx = 0;
  int   done_cnt = 0;
  int   hi_run = 0;
  int   align_seen = 0;
  int   align_len = 0;
  logic align_low = 1'b0;
  logic prev_rst = 1'b0;
  logic [7:0]    trig_sym = 8'h00;
  logic [NR-1:0] trig_mask = '0;
  logic [NR-1:0] rep_next = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Automata stand-in: report lines answer the issued symbol one cycle later.
  always @(posedge clk) begin
    #1;
    auto_report = rep_next;
  end

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (auto_run && prev_rst) begin
      align_seen++;
      align_low = !auto_reset;
      align_len = hi_run;
    end
    if (start) hi_run = 0;
    else if (auto_reset) hi_run++;
    else hi_run = 0;
    prev_rst = auto_reset;
    rep_next = (auto_run && auto_symbols == trig_sym) ? trig_mask : '0;
    if (auto_run) begin
      chk("sb_nonempty", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        chk("sb_sym", auto_symbols, mon_e.sym);
        chk("sb_cnt", sym_count, mon_e.idx + 1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    push_idx = 0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic push(input logic [7:0] s, input logic with_stop);
    int t;
    t = 0;
    sym_valid = 1'b1;
    sym_data  = s;
    while (!sym_ready && t < 50) begin
      tick();
      t++;
    end
    chk("push_rdy", sym_ready, 1);
    if (sym_ready) begin
      sb.push_back('{s, push_idx});
      push_idx++;
    end
    stop = with_stop;
    tick();
    sym_valid = 1'b0;
    stop = 1'b0;
  endtask

  task automatic wait_run(input string tag);
    int t;
    t = 0;
    while (!auto_run && t < 40) begin
      tick();
      t++;
    end
    chk(tag, auto_run, 1);
  endtask

  task automatic wait_done(input string tag);
    logic seen;
    seen = 1'b0;
    for (int t = 0; t < 60; t++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk(tag, seen, 1);
  endtask

  int d0, a0;

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; sym_valid = 1'b0; sym_data = '0;
    auto_report = '0;
    repeat (2) @(negedge clk);
    chk("rv_auto_reset", auto_reset, 1);
    chk("rv_auto_run", auto_run, 0);
    chk("rv_busy", busy, 0);
    chk("rv_ready", sym_ready, 0);
    chk("rv_done", done, 0);
    chk("rv_sym_count", sym_count, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    tick();
    pulse_stop();
    tick();
    chk("idle_stop_busy", busy, 0);
    chk("idle_auto_reset", auto_reset, 1);

    // Basic trace, report on the second symbol
    trig_sym = 8'h50; trig_mask = 4'b0001; d0 = done_cnt;
    do_start();
    chk("t1_busy", busy, 1);
    chk("t1_rst_ready", sym_ready, 1);
    push(8'h10, 1'b0);
    push(8'h50, 1'b0);
    push(8'h90, 1'b1);
    wait_done("t1_done");
    chk("t1_vec", report_vec, 4'b0001);
    chk("t1_vio", violation, 1);
    chk("t1_cnt", sym_count, 3);
`ifdef LTL_SEQ_REPORT_IDX_EN
    chk("t1_ridx", report_idx, 1);
`endif
    repeat (3) tick();
    chk("t1_done_once", done_cnt - d0, 1);
    chk("t1_idle_busy", busy, 0);
    chk("t1_idle_rst", auto_reset, 1);
    chk("t1_hold_vio", violation, 1);
    chk("t1_sb_empty", sb.size(), 0);

    // Reset alignment with two preloaded symbols
    trig_mask = '0; a0 = align_seen;
    do_start();
    chk("t2_clr_vio", violation, 0);
    chk("t2_clr_vec", report_vec, 0);
    push(8'h21, 1'b0);
    push(8'h22, 1'b0);
    pulse_stop();
    wait_done("t2_done");
    chk("t2_align_once", align_seen - a0, 1);
    chk("t2_align_low", align_low, 1);
    chk("t2_align_len", align_len >= RC, 1);
    chk("t2_cnt", sym_count, 2);

    // Back-to-back streaming once running
    do_start();
    push(8'h60, 1'b0);
    wait_run("t3_run");
    for (int i = 0; i < 6; i++) begin
      sym_valid = 1'b1;
      sym_data  = 8'(8'h61 + i);
      chk("t3_ready", sym_ready, 1);
      sb.push_back('{8'(8'h61 + i), push_idx});
      push_idx++;
      tick();
    end
    sym_valid = 1'b0;
    pulse_stop();
    wait_done("t3_done");
    chk("t3_cnt", sym_count, 7);
    chk("t3_sb_empty", sb.size(), 0);

    // Fill the FIFO while held in RST
    do_start();
    for (int i = 0; i < 4; i++) push(8'(8'h70 + i), 1'b0);
    chk("t3_full_ready", sym_ready, 0);
    tick();
    chk("t3_full_ready2", sym_ready, 0);
    pulse_stop();
    wait_done("t3f_done");
    chk("t3f_cnt", sym_count, 4);
    chk("t3f_sb_empty", sb.size(), 0);

    // Report only on the final symbol
    trig_sym = 8'h33; trig_mask = 4'b0100;
    do_start();
    push(8'h31, 1'b0);
    push(8'h32, 1'b0);
    push(8'h33, 1'b1);
    wait_done("t4_done");
    chk("t4_vio", violation, 1);
    chk("t4_vec", report_vec, 4'b0100);
    chk("t4_cnt", sym_count, 3);
`ifdef LTL_SEQ_REPORT_IDX_EN
    chk("t4_ridx", report_idx, 2);
`endif

    // Abort mid-RUN with three symbols buffered
    trig_sym = 8'h41; trig_mask = 4'b1000;
    do_start();
    for (int i = 0; i < 4; i++) push(8'(8'h41 + i), 1'b0);
    wait_run("t5_run");
    for (int i = 0; i < 2; i++) begin
      sym_valid = 1'b1;
      sym_data  = 8'(8'h45 + i);
      chk("t5_ready", sym_ready, 1);
      sb.push_back('{8'(8'h45 + i), push_idx});
      push_idx++;
      tick();
    end
    sym_valid = 1'b0;
    chk("t5_pre_vio", violation, 1);
    d0 = done_cnt;
    do_start();
    chk("t5_vio_clr", violation, 0);
    chk("t5_vec_clr", report_vec, 0);
    chk("t5_cnt_clr", sym_count, 0);
    chk("t5_auto_reset", auto_reset, 1);
    chk("t5_auto_run", auto_run, 0);
    chk("t5_busy", busy, 1);
    chk("t5_sb_left", sb.size(), 3);
    repeat (3) void'(sb.pop_back());
    repeat (10) tick();
    chk("t5_no_done", done_cnt - d0, 0);
    pulse_stop();
    wait_done("t5_done");
    chk("t5_final_cnt", sym_count, 0);

    // Asynchronous reset between edges
    trig_mask = '0;
    do_start();
    push(8'h81, 1'b0);
    push(8'h82, 1'b0);
    wait_run("t6_run");
    #2 rst = 1'b1;
    #1;
    chk("t6_auto_reset", auto_reset, 1);
    chk("t6_auto_run", auto_run, 0);
    chk("t6_busy", busy, 0);
    chk("t6_ready", sym_ready, 0);
    chk("t6_cnt", sym_count, 0);
    chk("t6_syms", auto_symbols, 0);
    sb.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) tick();
    chk("t6_idle_busy", busy, 0);
    chk("t6_idle_rst", auto_reset, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
